// File: rtl/nn_pkg.sv
// Shared types for the backprop controller: fp32 word, constants and the
// hidden-error sequencer state encoding.
package nn_pkg;

  typedef logic [31:0] fp32_t;

  localparam fp32_t FP_ONE = 32'h3f800000;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    HOLD,
    WRITE,
    DONE
  } hes_state_e;

endpackage

// File: rtl/latency_timer.sv
// Cycle counter that expires LATENCY cycles after a load: load clears it,
// count advances it, expired flags the final counted cycle.
module latency_timer #(
  parameter int LATENCY = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(LATENCY + 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && !expired) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign expired = (cnt_reg == CW'(LATENCY - 1));

endmodule

// File: rtl/hidden_error_sequencer.sv
// Walks every hidden unit through the shared in-error datapath: fetch operands,
// hold them stable for the full datapath latency, then write the result back.
module hidden_error_sequencer
  import nn_pkg::*;
#(
  parameter int N_HIDDEN   = 2,
  parameter int DP_LATENCY = 17,
  parameter int AW         = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  fp32_t         error_o,
  output logic [AW-1:0] rd_addr,
  input  fp32_t         mid_value,
  input  fp32_t         weight_v,
  output fp32_t         dp_mid,
  output fp32_t         dp_weight,
  output fp32_t         dp_error,
  input  fp32_t         dp_result,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output fp32_t         wr_data,
  output logic          busy,
  output logic          done
);

  hes_state_e    state_reg, state_next;
  logic [AW-1:0] idx_reg;
  fp32_t         dp_mid_reg, dp_weight_reg, dp_error_reg, result_reg;
  logic          timer_load, timer_count, timer_expired;
  logic          last_unit;

  assign last_unit = (idx_reg == AW'(N_HIDDEN - 1));

  latency_timer #(
    .LATENCY (DP_LATENCY)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .count   (timer_count),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_load  = 1'b0;
    timer_count = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = FETCH;
      FETCH: state_next = LOAD;
      LOAD: begin
        timer_load = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        timer_count = 1'b1;
        if (timer_expired) state_next = WRITE;
      end
      WRITE: state_next = last_unit ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands change only in LOAD, so both datapath branches settle before capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      dp_mid_reg    <= '0;
      dp_weight_reg <= '0;
      dp_error_reg  <= '0;
      result_reg    <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        dp_error_reg <= error_o;
        idx_reg      <= '0;
      end
      if (state_reg == LOAD) begin
        dp_mid_reg    <= mid_value;
        dp_weight_reg <= weight_v;
      end
      if (state_reg == HOLD && timer_expired) begin
        result_reg <= dp_result;
      end
      if (state_reg == WRITE && !last_unit) begin
        idx_reg <= idx_reg + AW'(1);
      end
    end
  end

  assign rd_addr   = idx_reg;
  assign wr_addr   = idx_reg;
  assign wr_data   = result_reg;
  assign wr_en     = (state_reg == WRITE);
  assign done      = (state_reg == DONE);
  assign busy      = (state_reg != IDLE) && (state_reg != DONE);
  assign dp_mid    = dp_mid_reg;
  assign dp_weight = dp_weight_reg;
  assign dp_error  = dp_error_reg;

endmodule
